// File: rtl/sop_sweep_pkg.sv
// sop_sweep_pkg: shared types and constants for the SOP truth-table sweeper.
//   state_e        : sequencer states
//   N_ROWS         : number of input rows of the 4-input function
//   EXPECTED_MASK_DEF : golden truth table (minterms 2, 9, 13, 15)
//   SETTLE_CNT_W   : width of the settle counter (SETTLE_CYCLES <= 2**SETTLE_CNT_W)
package sop_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    EMIT,
    DONE
  } state_e;

  localparam int unsigned N_ROWS            = 16;
  localparam logic [15:0] EXPECTED_MASK_DEF = 16'hA204;
  localparam int unsigned SETTLE_CNT_W      = 8;

endpackage

// File: rtl/sop_eval4.sv
// sop_eval4: combinational 4-input SOP function under test.
//   s = ~w&~x&y&~z | w&x&z | w&~y&z
// Ports:
//   w_i, x_i, y_i, z_i : function inputs (w is the row-index MSB)
//   s_o                : function output
module sop_eval4 (
  input  logic w_i,
  input  logic x_i,
  input  logic y_i,
  input  logic z_i,
  output logic s_o
);

  assign s_o = (~w_i & ~x_i &  y_i & ~z_i) |
               ( w_i &  x_i &  z_i)        |
               ( w_i & ~y_i &  z_i);

endmodule

// File: rtl/sop_sweep_controller.sv
// sop_sweep_controller: sweeps a 4-input combinational function through all
// 16 rows, holds each input vector for SETTLE_CYCLES, samples the result,
// streams it over a valid/ready port and accumulates the truth table.
// Optional macro: SOP_SWEEP_CHECK_EN enables the golden-mask compare that
// drives mismatch; otherwise mismatch is tied low.
// Ports:
//   clk, reset         : clock (rising edge), synchronous active-high reset
//   start              : begin a sweep (sampled only when idle)
//   busy, done         : sweep in progress / one-cycle completion pulse
//   vec_out            : {w,x,y,z} driven to the function, equals row index
//   f_in               : function output
//   row_valid/ready    : row result handshake
//   row_idx, row_val   : presented row and its sampled result
//   tt_mask, ones_cnt  : accumulated truth table and count of ones
//   mismatch           : tt_mask differs from EXPECTED_MASK
module sop_sweep_controller
  import sop_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECTED_MASK = EXPECTED_MASK_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  vec_out,
  input  logic        f_in,
  output logic        row_valid,
  input  logic        row_ready,
  output logic [3:0]  row_idx,
  output logic        row_val,
  output logic [15:0] tt_mask,
  output logic [4:0]  ones_cnt,
  output logic        mismatch
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    val_q, val_d;
  logic [15:0]             mask_q, mask_d;
  logic [4:0]              ones_q, ones_d;
`ifdef SOP_SWEEP_CHECK_EN
  logic                    mis_q, mis_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    mask_d  = mask_q;
    ones_d  = ones_q;
`ifdef SOP_SWEEP_CHECK_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          mask_d  = '0;
          ones_d  = '0;
`ifdef SOP_SWEEP_CHECK_EN
          mis_d   = 1'b0;
`endif
        end
      end
      DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          val_d         = f_in;
          mask_d[idx_q] = f_in;
          ones_d        = ones_q + 5'(f_in);
          cnt_d         = '0;
          state_d       = EMIT;
        end else begin
          cnt_d = cnt_q + SETTLE_CNT_W'(1);
        end
      end
      EMIT: begin
        if (row_ready) begin
          if (idx_q == 4'hF) begin
            state_d = DONE;
`ifdef SOP_SWEEP_CHECK_EN
            // mask is already final here, so the flag is valid during DONE
            mis_d   = (mask_q != EXPECTED_MASK);
`endif
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = DRIVE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      val_q   <= 1'b0;
      mask_q  <= '0;
      ones_q  <= '0;
`ifdef SOP_SWEEP_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      mask_q  <= mask_d;
      ones_q  <= ones_d;
`ifdef SOP_SWEEP_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // vec_out and row_idx share one register: both advance only on DRIVE entry
  assign vec_out   = idx_q;
  assign row_idx   = idx_q;
  assign row_val   = val_q;
  assign row_valid = (state_q == EMIT);
  assign busy      = (state_q == DRIVE) || (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign tt_mask   = mask_q;
  assign ones_cnt  = ones_q;
`ifdef SOP_SWEEP_CHECK_EN
  assign mismatch  = mis_q;
`else
  assign mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_sop_sweep_controller.sv
module tb_sop_sweep_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start3, row_ready;
  logic        f_force_en, f_force_val;
  logic        eval_s, eval3_s, f_in;
  logic        busy, done, row_valid, row_val, mismatch;
  logic [3:0]  vec_out, row_idx;
  logic [15:0] tt_mask;
  logic [4:0]  ones_cnt;
  logic        busy3, done3, row_valid3, row_val3, mismatch3;
  logic [3:0]  vec3, row_idx3;
  logic [15:0] tt_mask3;
  logic [4:0]  ones3;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  sop_eval4 u_eval (.w_i(vec_out[3]), .x_i(vec_out[2]), .y_i(vec_out[1]), .z_i(vec_out[0]), .s_o(eval_s));
  assign f_in = f_force_en ? f_force_val : eval_s;

  sop_sweep_controller #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .vec_out(vec_out), .f_in(f_in), .row_valid(row_valid), .row_ready(row_ready),
    .row_idx(row_idx), .row_val(row_val), .tt_mask(tt_mask), .ones_cnt(ones_cnt),
    .mismatch(mismatch)
  );

  sop_eval4 u_eval3 (.w_i(vec3[3]), .x_i(vec3[2]), .y_i(vec3[1]), .z_i(vec3[0]), .s_o(eval3_s));

  sop_sweep_controller #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .busy(busy3), .done(done3),
    .vec_out(vec3), .f_in(eval3_s), .row_valid(row_valid3), .row_ready(1'b1),
    .row_idx(row_idx3), .row_val(row_val3), .tt_mask(tt_mask3), .ones_cnt(ones3),
    .mismatch(mismatch3)
  );

  // Reference: the function is true exactly on minterms 2, 9, 13, 15
  function automatic bit ref_s(input int unsigned r);
    return (r == 2) || (r == 9) || (r == 13) || (r == 15);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_vec"}, vec_out, 0);
    check({tag, "_valid"}, row_valid, 0);
    check({tag, "_idx"}, row_idx, 0);
    check({tag, "_val"}, row_val, 0);
    check({tag, "_mask"}, tt_mask, 0);
    check({tag, "_ones"}, ones_cnt, 0);
    check({tag, "_mis"}, mismatch, 0);
  endtask

  // One full sweep on dut. stall_pct: chance of row_ready low per valid cycle;
  // stall9: hold row_ready low 3 cycles on row 9; poke_row: pulse start there.
  task automatic run_sweep(input int unsigned stall_pct, input bit stall9,
                           input bit force_one, input int poke_row);
    int unsigned exp_row, cyc, stalls, s9, dones, ones;
    logic [15:0] exp_mask;
    logic        exp_mis;
    bit          fin;
    exp_mask = '0;
    ones = 0;
    for (int unsigned r = 0; r < 16; r++) begin
      exp_mask[r] = force_one ? 1'b1 : ref_s(r);
      ones += exp_mask[r];
    end
`ifdef SOP_SWEEP_CHECK_EN
    exp_mis = (exp_mask != 16'hA204);
`else
    exp_mis = 1'b0;
`endif
    @(negedge clk);
    f_force_en = force_one; f_force_val = 1'b1;
    start = 1'b1; row_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; exp_row = 0; stalls = 0; s9 = 0; dones = 0; fin = 0;
    while (!fin && cyc < 2000) begin
      if (done) begin
        dones++;
        check("done_cycle", cyc, 32 + stalls);
        check("done_busy", busy, 0);
        check("done_mask", tt_mask, exp_mask);
        check("done_ones", ones_cnt, ones);
        check("done_mis", mismatch, exp_mis);
        fin = 1;
      end else begin
        check("busy", busy, 1);
        check("vec_out", vec_out, exp_row);
        if (row_valid) begin
          check("row_idx", row_idx, exp_row);
          check("row_val", row_val, exp_mask[exp_row[3:0]]);
          if (stall9 && exp_row == 9 && s9 < 3) begin
            row_ready = 1'b0; s9++;
          end else begin
            row_ready = ($urandom_range(99) >= stall_pct);
          end
          if (row_ready) exp_row++;
          else stalls++;
        end else begin
          row_ready = 1'($urandom_range(1));
        end
        start = (poke_row >= 0 && exp_row == 32'(poke_row));
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", fin, 1);
    start = 1'b0; row_ready = 1'b0;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("hold_mask", tt_mask, exp_mask);
    check("hold_ones", ones_cnt, ones);
    check("hold_mis", mismatch, exp_mis);
    check("done_count", dones, 1);
    f_force_en = 1'b0;
  endtask

  initial begin
    int unsigned cyc;
    bit fin;
    reset = 1'b1; start = 1'b0; start3 = 1'b0; row_ready = 1'b0;
    f_force_en = 1'b0; f_force_val = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_zero("reset");
    check("reset3_busy", busy3, 0);
    check("reset3_mask", tt_mask3, 0);

    run_sweep(0, 1'b0, 1'b0, -1);   // full throughput, done at cycle 32
    run_sweep(0, 1'b1, 1'b0, -1);   // 3-cycle stall on row 9
    run_sweep(30, 1'b0, 1'b0, 5);   // start poked while busy, random stalls

    // Reset in the middle of a sweep at row 7
    @(negedge clk);
    start = 1'b1; row_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(row_valid && row_idx == 4'd7) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_row7", row_idx, 7);
    reset = 1'b1; row_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_idle_zero("midreset");
    @(negedge clk);
    check("midreset_no_done", done, 0);

    run_sweep(50, 1'b0, 1'b0, -1);  // restart from row 0 after reset
    run_sweep(20, 1'b0, 1'b1, -1);  // f_in forced high
    run_sweep(0, 1'b0, 1'b0, -1);   // correct function again

    // SETTLE_CYCLES = 3 instance: each row spans 4 cycles
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 0; fin = 0;
    while (!fin && cyc < 500) begin
      if (done3) begin
        check("s3_done_cycle", cyc, 64);
        check("s3_mask", tt_mask3, 16'hA204);
        check("s3_ones", ones3, 4);
        fin = 1;
      end else begin
        check("s3_vec", vec3, cyc / 4);
        check("s3_valid", row_valid3, (cyc % 4) == 3);
        @(negedge clk);
        cyc++;
      end
    end
    check("s3_done_seen", fin, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
